// File: rtl/adder_8bit_sync.sv
// Single-stage registered adder for the ALU datapath: ripple-carry sum of A+B+Cin
// with carry, signed-overflow and zero flags, qualified by out_valid.
module adder_8bit_sync #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] raw_sum;
  logic             carry_out;
  logic             overflow_next;
  logic [WIDTH-1:0] final_sum;

  // Carry is walked through a single block variable so the chain has no
  // self-referencing vector between bits.
  always_comb begin
    logic c;
    c       = Cin;
    raw_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw_sum[i] = A[i] ^ B[i] ^ c;
      c          = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    carry_out = c;
  end

  // Overflow is judged on the unsaturated result.
  assign overflow_next = (A[WIDTH-1] == B[WIDTH-1]) && (raw_sum[WIDTH-1] != A[WIDTH-1]);
  assign final_sum     = (SATURATE && carry_out) ? {WIDTH{1'b1}} : raw_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum      <= final_sum;
        Cout     <= carry_out;
        Overflow <= overflow_next;
        Zero     <= (final_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_8bit_sync.sv
// Bench for adder_8bit_sync: wrapping and saturating instances driven in parallel,
// checked against an integer-arithmetic reference model.
module tb_adder_8bit_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin;

  logic [7:0] sum, sum_s;
  logic       cout, cout_s, ovf, ovf_s, zero, zero_s, ov, ov_s;

  int errors = 0;
  int checks = 0;

  // model state: last registered result of each instance
  logic [7:0] m_sum,  m_sum_s;
  logic       m_cout, m_ovf, m_zero, m_zero_s, m_ov;

  always #5 clk = ~clk;

  adder_8bit_sync #(.WIDTH(8), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b), .Cin(cin),
    .Sum(sum), .Cout(cout), .Overflow(ovf), .Zero(zero), .out_valid(ov));

  adder_8bit_sync #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b), .Cin(cin),
    .Sum(sum_s), .Cout(cout_s), .Overflow(ovf_s), .Zero(zero_s), .out_valid(ov_s));

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  task automatic model(input logic rst, input logic vld, input logic [7:0] ma,
                       input logic [7:0] mb, input logic mc);
    int u, s;
    if (rst) begin
      m_sum = 0; m_sum_s = 0; m_cout = 0; m_ovf = 0; m_zero = 0; m_zero_s = 0; m_ov = 0;
      return;
    end
    m_ov = vld;
    if (!vld) return;
    u = int'(ma) + int'(mb) + int'(mc);
    s = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    m_sum    = u[7:0];
    m_cout   = (u > 255);
    m_ovf    = (s > 127) || (s < -128);
    m_zero   = (m_sum == 8'd0);
    m_sum_s  = m_cout ? 8'hFF : m_sum;
    m_zero_s = (m_sum_s == 8'd0);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] da,
                       input logic [7:0] db, input logic dc);
    rst_n = r; in_valid = v; a = da; b = db; cin = dc;
    model(!r, v, da, db, dc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 8'h55, 8'h55, 1'b1);
    checks++;
    if ({sum, cout, ovf, zero, ov} !== 12'h000) begin
      errors++;
      $display("FAIL reset_wrap: got %h expected 000", {sum, cout, ovf, zero, ov});
    end
    checks++;
    if ({sum_s, cout_s, ovf_s, zero_s, ov_s} !== 12'h000) begin
      errors++;
      $display("FAIL reset_sat: got %h expected 000", {sum_s, cout_s, ovf_s, zero_s, ov_s});
    end
  endtask

  task automatic test_directed;
    logic [7:0] ta [6] = '{8'h00, 8'hFF, 8'd135, 8'h7F, 8'hFF, 8'h80};
    logic [7:0] tb [6] = '{8'h00, 8'hFF, 8'h0A, 8'h01, 8'h00, 8'h80};
    logic       tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // expected {Sum, Cout, Overflow, Zero} of the wrapping instance
    logic [10:0] te [6] = '{{8'h00, 3'b001}, {8'hFE, 3'b100}, {8'h91, 3'b000},
                            {8'h80, 3'b010}, {8'h00, 3'b101}, {8'h00, 3'b111}};
    logic [7:0]  ts [6] = '{8'h00, 8'hFF, 8'h91, 8'h80, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, ta[i], tb[i], tc[i]);
      checks++;
      if ({sum, cout, ovf, zero, ov} !== {te[i], 1'b1}) begin
        errors++;
        $display("FAIL directed_%0d: got %h expected %h", i, {sum, cout, ovf, zero, ov}, {te[i], 1'b1});
      end
      checks++;
      if ({sum_s, cout_s} !== {ts[i], te[i][2]}) begin
        errors++;
        $display("FAIL directed_sat_%0d: got %h expected %h", i, {sum_s, cout_s}, {ts[i], te[i][2]});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3] = '{8'd3, 8'd7, 8'd11};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'(2*i + 1), 8'(2*i + 2), 1'b0);
      checks++;
      if ({sum, ov} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL b2b_%0d: got sum=%0d ov=%b expected sum=%0d ov=1", i, sum, ov, exp[i]);
      end
    end
    drive(1'b1, 1'b0, 8'hAA, 8'h33, 1'b1);
    checks++;
    if ({sum, cout, ovf, zero, ov} !== {8'd11, 4'b0000}) begin
      errors++;
      $display("FAIL b2b_hold: got %h expected %h", {sum, cout, ovf, zero, ov}, {8'd11, 4'b0000});
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 1'b1, 8'h10, 8'h20, 1'b0);
    drive(1'b0, 1'b1, 8'h55, 8'h55, 1'b0);
    checks++;
    if ({sum, cout, ovf, zero, ov} !== 12'h000) begin
      errors++;
      $display("FAIL midreset: got %h expected 000", {sum, cout, ovf, zero, ov});
    end
    drive(1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    checks++;
    if ({sum, cout, ovf, zero, ov} !== {8'hAA, 4'b0101}) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", {sum, cout, ovf, zero, ov}, {8'hAA, 4'b0101});
    end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if ({sum, cout, ovf, zero, ov} !== {m_sum, m_cout, m_ovf, m_zero, m_ov}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random_wrap_%0d: a=%h b=%h cin=%b got %h expected %h", i, a, b, cin,
                   {sum, cout, ovf, zero, ov}, {m_sum, m_cout, m_ovf, m_zero, m_ov});
      end
      checks++;
      if ({sum_s, cout_s, ovf_s, zero_s, ov_s} !== {m_sum_s, m_cout, m_ovf, m_zero_s, m_ov}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random_sat_%0d: a=%h b=%h cin=%b got %h expected %h", i, a, b, cin,
                   {sum_s, cout_s, ovf_s, zero_s, ov_s}, {m_sum_s, m_cout, m_ovf, m_zero_s, m_ov});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
